// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider slice: the operand width,
// the controller state encoding and the number of restoring iterations.
// No ports; imported by div_seq.
// ---------------------------------------------------------------------------
package div_pkg;

   // Operand / result width used by the divider.
   localparam int XLEN = 32;

   // One quotient bit is produced per iteration.
   localparam int ITERS = 32;

   // Width of the iteration counter; it wraps naturally after the last step.
   localparam int CNT_W = $clog2(ITERS);

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_seq_adder.sv
// ---------------------------------------------------------------------------
// adder
// Plain W-bit adder/subtractor.  With sub=1 it computes a - b by adding the
// one's complement of b plus a carry-in of one.
// Ports:
//   a, b : operands
//   sub  : 0 = add, 1 = subtract
//   o    : W-bit result (carry-out discarded)
// ---------------------------------------------------------------------------
module adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] o
);

   logic [W-1:0] w_bInv;
   logic [W-1:0] w_carryIn;

   // Subtraction reuses the same add path: invert b and inject a carry of one.
   assign w_bInv    = b ^ {W{sub}};
   assign w_carryIn = {{(W-1){1'b0}}, sub};
   assign o         = a + w_bInv + w_carryIn;

endmodule

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// Unsigned restoring divider, one quotient bit per clock.  A request is
// accepted when start=1 while ready=1.  Division by zero finishes at once
// with quotient all-ones and remainder equal to the dividend.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start     : request, only looked at while ready=1
//   dividend  : unsigned dividend, sampled on the accept edge
//   divisor   : unsigned divisor, sampled on the accept edge
//   ready     : high while idle
//   done      : one-cycle pulse, quotient/remainder valid
//   quotient  : registered quotient (held until the next accept)
//   remainder : registered remainder (held until the next accept)
// ---------------------------------------------------------------------------
module div_seq
   import div_pkg::*;
#(
   parameter int XLEN = div_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            ready,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   state_t           r_state;
   logic [XLEN-1:0]  r_quot;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_divisor;
   logic [CNT_W-1:0] r_cnt;

   logic [XLEN-1:0]  w_shifted;
   logic [XLEN-1:0]  w_diff;
   logic             w_sub;
   logic             w_take;
   logic             w_lastIter;

   // The next dividend bit comes out of the top of the quotient register,
   // which starts out holding the dividend and fills with quotient bits.
   assign w_shifted = {r_rem[XLEN-2:0], r_quot[XLEN-1]};

   // The only arithmetic unit; it subtracts whenever the divider is iterating.
   assign w_sub = (r_state == RUN);

   adder #(
      .W (XLEN)
   ) u_adder (
      .a   (w_shifted),
      .b   (r_divisor),
      .sub (w_sub),
      .o   (w_diff)
   );

   // The true partial remainder is XLEN+1 bits wide; when the bit shifted out
   // of r_rem is set it is certainly >= divisor, and the XLEN-bit difference
   // is still exact because the result fits back into XLEN bits.
   assign w_take     = r_rem[XLEN-1] | (w_shifted >= r_divisor);
   assign w_lastIter = (r_cnt == CNT_W'(ITERS - 1));

   assign ready     = (r_state == IDLE);
   assign done      = (r_state == DONE);
   assign quotient  = r_quot;
   assign remainder = r_rem;

   // Controller and datapath registers.  Results are not cleared on the way
   // back to IDLE so they stay readable until the next request is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_quot    <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     r_quot  <= '1;
                     r_rem   <= dividend;
                     r_state <= DONE;
                  end else begin
                     r_divisor <= divisor;
                     r_quot    <= dividend;
                     r_rem     <= '0;
                     r_cnt     <= '0;
                     r_state   <= RUN;
                  end
               end
            end
            RUN: begin
               r_rem  <= w_take ? w_diff : w_shifted;
               r_quot <= {r_quot[XLEN-2:0], w_take};
               r_cnt  <= r_cnt + 1'b1;
               if (w_lastIter) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
// Self-checking bench for div_seq.  Expected results are computed with the
// simulator's own / and % operators, queued when a request is driven and
// compared when done is seen.
// ---------------------------------------------------------------------------
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        ready;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int          vectorCount = 0;
   int          missCount = 0;
   logic [63:0] expQueue[$];

   div_seq #(
      .XLEN (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .ready     (ready),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected it to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference result {quotient, remainder}.
   function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) begin
         return {32'hFFFF_FFFF, a};
      end
      return {a / b, a % b};
   endfunction

   // Drive one request for a single cycle and queue its expected result.
   // Returns at 1 ns after the accept edge with the operands scrambled.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      expQueue.push_back(refDiv(a, b));
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Called 1 ns after an accept edge.  Counts edges until done, checks the
   // result against the scoreboard, then checks the return to IDLE.
   // injectAt >= 0 pulses a 9/3 request while the divider is busy.
   task automatic waitDone(input int expLat, input int injectAt);
      int          lat = 0;
      int          readyBad = 0;
      logic        seen = 1'b0;
      logic [63:0] expRes;
      while (lat <= 64) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (ready) readyBad++;
         if (lat == injectAt) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd3;
         end
         @(posedge clk);
         #1;
         if (lat == injectAt) begin
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
         end
         lat++;
      end
      checkOutput("doneSeen", 32'(seen), 32'd1);
      if (seen) begin
         checkOutput("latency", 32'(lat), 32'(expLat));
         checkOutput("readyLowBusy", 32'(readyBad), 32'd0);
         checkOutput("readyLowDone", 32'(ready), 32'd0);
         if (expQueue.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd0, 32'd1);
         end else begin
            expRes = expQueue.pop_front();
            checkOutput("quotient", quotient, expRes[63:32]);
            checkOutput("remainder", remainder, expRes[31:0]);
            @(posedge clk);
            #1;
            checkOutput("donePulseEnds", 32'(done), 32'd0);
            checkOutput("readyIdle", 32'(ready), 32'd1);
            checkOutput("holdQuotient", quotient, expRes[63:32]);
            checkOutput("holdRemainder", remainder, expRes[31:0]);
         end
      end
   endtask

   initial begin
      int          doneCount;
      int          readyDrop;
      logic [31:0] a;
      logic [31:0] b;

      $display("[TB] div_seq bench starting");

      // Asynchronous reset takes effect before any clock edge.
      #1 rst = 1'b1;
      #2;
      checkOutput("rstReady", 32'(ready), 32'd1);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstQuotient", quotient, 32'd0);
      checkOutput("rstRemainder", remainder, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic case.
      applyStimulus(32'd100, 32'd7);
      waitDone(32, -1);

      // Divide by zero finishes on the accept edge itself.
      applyStimulus(32'h1234_5678, 32'd0);
      waitDone(0, -1);

      // Boundary operands.
      applyStimulus(32'hFFFF_FFFF, 32'd1);
      waitDone(32, -1);
      applyStimulus(32'hFFFF_FFFF, 32'h8000_0000);
      waitDone(32, -1);
      applyStimulus(32'd5, 32'd10);
      waitDone(32, -1);

      // A start pulse while busy must be ignored entirely.
      applyStimulus(32'd100, 32'd7);
      waitDone(32, 10);
      doneCount = 0;
      readyDrop = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) doneCount++;
         if (!ready) readyDrop++;
      end
      checkOutput("noExtraDone", 32'(doneCount), 32'd0);
      checkOutput("noQueuedAccept", 32'(readyDrop), 32'd0);

      // Start held high: a new accept on the first IDLE cycle after DONE.
      @(negedge clk);
      start    = 1'b1;
      dividend = 32'd20;
      divisor  = 32'd3;
      expQueue.push_back(refDiv(32'd20, 32'd3));
      expQueue.push_back(refDiv(32'd20, 32'd3));
      @(posedge clk);
      #1;
      waitDone(32, -1);
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      waitDone(32, -1);

      // Reset between clock edges in the middle of an operation.
      applyStimulus(32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("abortReady", 32'(ready), 32'd1);
      checkOutput("abortDone", 32'(done), 32'd0);
      checkOutput("abortQuotient", quotient, 32'd0);
      checkOutput("abortRemainder", remainder, 32'd0);
      void'(expQueue.pop_back());
      @(posedge clk);
      #1 rst = 1'b0;
      // Accepted on the first edge after reset; any leftover done from the
      // aborted request would show up as a wrong latency here.
      applyStimulus(32'd50, 32'd5);
      waitDone(32, -1);

      // A few random requests, including the large-divisor path.
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i == 3) b = 32'd0;
         if (i == 4) b = 32'hC000_0001;
         applyStimulus(a, b);
         waitDone((b == 32'd0) ? 0 : 32, -1);
      end

      checkOutput("scoreboardDrained", 32'(expQueue.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
